// File: rtl/score_disp_pkg.sv
// Shared types, segment constants and BCD helper for the score display scheduler.
package score_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Index of the final note bit consumed in SCAN
    localparam logic [3:0] LAST_BIT = 4'd14;

    // Two-digit BCD increment {tens, units}; units wrap 9 -> 0 with carry
    function automatic logic [7:0] bcd_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern.
module seg7_decode
    import score_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Map each BCD value to its pattern; non-BCD codes show a dash
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/score_display_sched.sv
// Tallies a 15-note hit vector into BCD hit/miss counts and multiplexes
// them onto a four-digit active-low seven-segment display.
module score_display_sched
    import score_disp_pkg::*;
#(
    parameter int REFRESH_BITS = 17
) (
    input  logic        segclk,
    input  logic        clr,
    input  logic        start,
    input  logic [14:0] hits,
    output logic        busy,
    output logic        done,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam logic [REFRESH_BITS-1:0] REFRESH_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [14:0]             r_shift;
    logic [3:0]              r_bitcnt;
    logic [7:0]              r_hit;
    logic [7:0]              r_miss;
    logic [7:0]              r_disp_hit;
    logic [7:0]              r_disp_miss;
    logic                    r_valid;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic [1:0]              r_digit;
    logic                    r_busy;
    logic                    r_done;
    logic [6:0]              r_seg;
    logic [3:0]              r_an;

    logic [7:0]              w_disp_hit_nxt;
    logic [7:0]              w_disp_miss_nxt;
    logic                    w_valid_nxt;
    logic [1:0]              w_digit_nxt;
    logic [3:0]              w_nib;
    logic                    w_is_tens;
    logic [6:0]              w_dec;
    logic [6:0]              w_seg_nxt;
    logic [3:0]              w_an_nxt;

    // State register
    always_ff @(posedge segclk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one start request, fifteen scan cycles, one latch cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (r_bitcnt == LAST_BIT) begin
                    w_state_nxt = ST_LATCH;
                end else begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_LATCH: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Snapshot the hit vector and accumulate BCD hit/miss counts
    always_ff @(posedge segclk) begin
        if (clr) begin
            r_shift  <= 15'd0;
            r_bitcnt <= 4'd0;
            r_hit    <= 8'd0;
            r_miss   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift  <= hits;
                        r_bitcnt <= 4'd0;
                        r_hit    <= 8'd0;
                        r_miss   <= 8'd0;
                    end
                end
                ST_SCAN: begin
                    r_shift  <= {1'b0, r_shift[14:1]};
                    r_bitcnt <= r_bitcnt + 4'd1;
                    if (r_shift[0]) begin
                        r_hit <= bcd_inc(r_hit);
                    end else begin
                        r_miss <= bcd_inc(r_miss);
                    end
                end
                default: begin
                    r_shift <= r_shift;
                end
            endcase
        end
    end

    // Display registers only change in LATCH so the old result stays visible during a tally
    always_comb begin
        w_disp_hit_nxt  = r_disp_hit;
        w_disp_miss_nxt = r_disp_miss;
        w_valid_nxt     = r_valid;
        if (r_state == ST_LATCH) begin
            w_disp_hit_nxt  = r_hit;
            w_disp_miss_nxt = r_miss;
            w_valid_nxt     = 1'b1;
        end else begin
            w_valid_nxt     = r_valid;
        end
    end

    // Display result registers
    always_ff @(posedge segclk) begin
        if (clr) begin
            r_disp_hit  <= 8'd0;
            r_disp_miss <= 8'd0;
            r_valid     <= 1'b0;
        end else begin
            r_disp_hit  <= w_disp_hit_nxt;
            r_disp_miss <= w_disp_miss_nxt;
            r_valid     <= w_valid_nxt;
        end
    end

    // Free-running refresh counter; each wrap moves to the next digit
    always_ff @(posedge segclk) begin
        if (clr) begin
            r_refresh <= {REFRESH_BITS{1'b0}};
            r_digit   <= 2'd0;
        end else begin
            r_refresh <= r_refresh + REFRESH_ONE;
            r_digit   <= w_digit_nxt;
        end
    end

    // Select the nibble for the upcoming digit, using next-cycle values so
    // the registered segment output tracks digit and result changes without lag
    always_comb begin
        w_digit_nxt = (&r_refresh) ? r_digit + 2'd1 : r_digit;
        w_nib       = 4'd0;
        w_is_tens   = 1'b0;
        case (w_digit_nxt)
            2'd3: begin w_nib = w_disp_hit_nxt[7:4];  w_is_tens = 1'b1; end
            2'd2: begin w_nib = w_disp_hit_nxt[3:0];  w_is_tens = 1'b0; end
            2'd1: begin w_nib = w_disp_miss_nxt[7:4]; w_is_tens = 1'b1; end
            2'd0: begin w_nib = w_disp_miss_nxt[3:0]; w_is_tens = 1'b0; end
            default: begin w_nib = 4'd0; w_is_tens = 1'b0; end
        endcase
        w_an_nxt = ~(4'b0001 << w_digit_nxt);
        if (!w_valid_nxt) begin
            w_seg_nxt = SEG_DASH;
        end else if (w_is_tens && (w_nib == 4'd0)) begin
            w_seg_nxt = SEG_BLANK;
        end else begin
            w_seg_nxt = w_dec;
        end
    end

    seg7_decode u_decode (
        .i_bcd (w_nib),
        .o_seg (w_dec)
    );

    // Registered outputs
    always_ff @(posedge segclk) begin
        if (clr) begin
            r_seg  <= SEG_DASH;
            r_an   <= 4'b1110;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_seg  <= w_seg_nxt;
            r_an   <= w_an_nxt;
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (w_state_nxt == ST_LATCH);
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign seg  = r_seg;
    assign an   = r_an;

endmodule

// File: tb/tb_score_display_sched.sv
// Self-checking bench for score_display_sched with a fast refresh (REFRESH_BITS=2).
module tb_score_display_sched;

    logic        segclk;
    logic        clr;
    logic        start;
    logic [14:0] hits;
    logic        busy;
    logic        done;
    logic [6:0]  seg;
    logic [3:0]  an;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit m_on    = 1'b0;
    int m_k     = 0;   // edges since clr released
    int m_left  = 0;   // cycles left until the tally finishes (0 = idle)
    int m_snap  = 0;   // hit count of the accepted snapshot
    int m_res   = 0;   // hit count currently displayed
    bit m_valid = 1'b0;

    logic [6:0] pat [10];
    int nd;
    int fd;
    int cyc;

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    score_display_sched #(.REFRESH_BITS(2)) dut (
        .segclk (segclk),
        .clr    (clr),
        .start  (start),
        .hits   (hits),
        .busy   (busy),
        .done   (done),
        .seg    (seg),
        .an     (an)
    );

    initial segclk = 1'b0;
    always #5 segclk = ~segclk;

    // Model: a tally takes 16 cycles after start; the result shows once it ends
    always @(posedge segclk) begin
        if (clr) begin
            m_on    <= 1'b1;
            m_k     <= 0;
            m_left  <= 0;
            m_valid <= 1'b0;
        end else begin
            m_k <= m_k + 1;
            if (m_left == 0) begin
                if (start) begin
                    m_left <= 16;
                    m_snap <= $countones(hits);
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_valid <= 1'b1;
                    m_res   <= m_snap;
                end
            end
        end
    end

    function automatic logic [6:0] exp_seg(input int idx);
        int v;
        bit tens;
        if (!m_valid) return DASH;
        case (idx)
            3: begin v = m_res / 10;        tens = 1'b1; end
            2: begin v = m_res % 10;        tens = 1'b0; end
            1: begin v = (15 - m_res) / 10; tens = 1'b1; end
            default: begin v = (15 - m_res) % 10; tens = 1'b0; end
        endcase
        if (tens && v == 0) return BLANK;
        return pat[v];
    endfunction

    task automatic compare(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of all outputs against the model
    task automatic checker_loop();
        int idx;
        logic [3:0] an_exp;
        forever begin
            @(negedge segclk);
            if (m_on) begin
                idx    = (m_k / 4) % 4;
                an_exp = ~(4'b0001 << idx);
                compare("busy", {6'd0, busy}, {6'd0, (m_left > 0)});
                compare("done", {6'd0, done}, {6'd0, (m_left == 1)});
                compare("an",   {3'd0, an},   {3'd0, an_exp});
                compare("seg",  seg,          exp_seg(idx));
            end
        end
    endtask

    // Wait (bounded) for digit idx to be enabled, then check its literal pattern
    task automatic check_digit(input int idx, input logic [6:0] exp, input string name);
        logic [3:0] want;
        want = ~(4'b0001 << idx);
        @(negedge segclk);
        for (int i = 0; i < 20 && an !== want; i++) @(negedge segclk);
        compare({name, "_an"}, {3'd0, an}, {3'd0, want});
        compare(name, seg, exp);
    endtask

    // Issue one tally, scramble hits afterwards, check done latency
    task automatic run_tally(input logic [14:0] h, input string name);
        hits  = h;
        start = 1'b1;
        @(negedge segclk);
        start = 1'b0;
        hits  = ~h;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge segclk);
            cyc++;
        end
        compare({name, "_latency"}, cyc[6:0], 7'd16);
    endtask

    initial begin
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
        pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
        pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
        pat[9] = 7'b0010000;
        clr   = 1'b1;
        start = 1'b1;
        hits  = 15'h7FFF;
        fork
            checker_loop();
        join_none
        repeat (3) @(negedge segclk);
        clr   = 1'b0;
        start = 1'b0;
        hits  = 15'h0000;

        // Idle rotation: dashes on every digit
        for (int d = 0; d < 4; d++) check_digit(d, DASH, "idle_dash");

        // 6 hits, 9 misses
        run_tally(15'h0555, "t0555");
        check_digit(3, BLANK,      "t0555_d3");
        check_digit(2, 7'b0000010, "t0555_d2");
        check_digit(1, BLANK,      "t0555_d1");
        check_digit(0, 7'b0010000, "t0555_d0");

        // 15 hits, 0 misses
        run_tally(15'h7FFF, "t7fff");
        check_digit(3, 7'b1111001, "t7fff_d3");
        check_digit(2, 7'b0010010, "t7fff_d2");
        check_digit(1, BLANK,      "t7fff_d1");
        check_digit(0, 7'b1000000, "t7fff_d0");

        // 0 hits, 15 misses
        run_tally(15'h0000, "t0000");
        check_digit(3, BLANK,      "t0000_d3");
        check_digit(2, 7'b1000000, "t0000_d2");
        check_digit(1, 7'b1111001, "t0000_d1");
        check_digit(0, 7'b0010010, "t0000_d0");

        // Restart attempt at N+5 and hits toggling during SCAN are ignored
        hits  = 15'h0555;
        start = 1'b1;
        @(negedge segclk);
        start = 1'b0;
        nd = 0;
        fd = 0;
        for (int c = 1; c <= 30; c++) begin
            if (done === 1'b1) begin
                nd++;
                if (fd == 0) fd = c;
            end
            start = (c == 5);
            hits  = (c == 5) ? 15'h7FFF : (hits ^ 15'h2A5A);
            @(negedge segclk);
        end
        start = 1'b0;
        compare("restart_done_count", nd[6:0], 7'd1);
        compare("restart_done_cycle", fd[6:0], 7'd16);
        check_digit(2, 7'b0000010, "restart_d2");
        check_digit(0, 7'b0010000, "restart_d0");

        // clr at N+8 aborts the tally
        hits  = 15'h7FFF;
        start = 1'b1;
        @(negedge segclk);
        start = 1'b0;
        repeat (7) @(negedge segclk);
        clr = 1'b1;
        @(negedge segclk);
        clr = 1'b0;
        compare("abort_busy", {6'd0, busy}, 7'd0);
        compare("abort_an",   {3'd0, an},   7'b0001110);
        compare("abort_seg",  seg,          DASH);
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) nd++;
            @(negedge segclk);
        end
        compare("abort_no_done", nd[6:0], 7'd0);
        check_digit(3, DASH, "abort_d3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_display_sched.md
SCORE_DISPLAY_SCHED -- requirements
Module: score_display_sched

Interface
REQ-001 Parameter REFRESH_BITS, default 17: width of the free-running refresh counter; the displayed digit advances once every 2^REFRESH_BITS segclk cycles.
REQ-002 segclk  input  1  sole clock; all state changes on its rising edge.
REQ-003 clr  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  single-cycle request to tally a new hit vector.
REQ-005 hits  input  15  per-note hit flags (1 = hit); bit 0 is the first note.
REQ-006 busy  output  1  high while a tally is in progress.
REQ-007 done  output  1  one-cycle pulse when a new result is loaded for display.
REQ-008 seg  output  7  segment pattern {g,f,e,d,c,b,a}, active-low.
REQ-009 an  output  4  digit enables, active-low, one-hot; an[0] is the rightmost digit.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SCAN and LATCH.
REQ-011 In IDLE, start=1 SHALL snapshot hits into a 15-bit shift register, clear the hit and miss BCD counters, and enter SCAN on the next cycle.
REQ-012 SCAN SHALL consume one bit per cycle, bit 0 first, for exactly 15 cycles, then enter LATCH.
REQ-013 Each consumed bit SHALL increment the hit counter if 1, else the miss counter.
REQ-014 Each counter SHALL be 2-digit BCD; the units digit wraps from 9 to 0 with a carry into tens; the maximum value is 15, so there is no overflow.
REQ-015 LATCH SHALL copy both counters into the display registers, set the result-valid flag, pulse done for one cycle, and return to IDLE.
REQ-016 Latency: start sampled at cycle N -> SCAN occupies N+1..N+15 -> LATCH and done at N+16 -> new digits on seg from N+17.
REQ-017 busy SHALL be 1 in SCAN and LATCH and 0 in IDLE.
REQ-018 start SHALL be ignored in SCAN and LATCH; changes on hits after the snapshot SHALL NOT affect the result.
REQ-019 The display registers SHALL hold the previous result throughout a new tally until LATCH.
REQ-020 The refresh counter SHALL run in every state and wrap modulo 2^REFRESH_BITS; at each wrap the digit index SHALL advance 0->1->2->3->0.
REQ-021 Digit index i SHALL drive an[i]=0 with all other an bits 1.
REQ-022 Digit mapping SHALL be: 3 = hits tens, 2 = hits units, 1 = misses tens, 0 = misses units.
REQ-023 A tens digit equal to 0 SHALL be blanked (seg=7'b1111111); a units digit SHALL never be blanked.
REQ-024 While the valid flag is 0, every digit SHALL show dash (7'b0111111).
REQ-025 seg and an SHALL be registered, changing only at digit-index changes or after display-register updates.
REQ-026 The required patterns are: 0=1000000, 1=1111001, 5=0010010, 6=0000010, 9=0010000; the other BCD values use standard active-low encodings.

Reset
REQ-027 clr=1 SHALL force: IDLE, shift register and all counters 0, refresh counter 0, digit index 0, valid 0, busy 0, done 0, an=4'b1110, seg=dash.
REQ-028 clr SHALL take priority over start, and a clr during SCAN or LATCH SHALL abort the tally with no done pulse.

Structure
REQ-029 The package score_disp_pkg SHALL hold the state encoding and the DASH, BLANK and digit-pattern constants.
REQ-030 The BCD-to-pattern decode SHALL be the single sub-module seg7_decode (combinational 4-bit in, 7-bit out); the FSM, counters and refresh logic SHALL stay in score_display_sched.

Verification (REFRESH_BITS=2 in the bench)
REQ-031 Release clr with no start -> all four digits show 0111111 in rotation, an sequence 1110,1101,1011,0111, busy=0.
REQ-032 start with hits=15'h0555 -> done at N+16 -> digits 3..0 show blank, 6 (0000010), blank, 9 (0010000).
REQ-033 start with hits=15'h7FFF -> digits 3..0 show 1, 5, blank, 0; start with hits=0 -> blank, 0, 1, 5.
REQ-034 Pulse start again at N+5 and toggle hits during SCAN -> no restart, single done at N+16, result equals the original snapshot.
REQ-035 Assert clr at N+8 mid-SCAN -> busy=0 next cycle, no done pulse, dashes displayed, an=1110.
